// File: rtl/rnd_bank_sampler_if.sv
// rnd_bank_sampler_if
//   Groups the requester handshake and the generator-bank control lines of
//   rnd_bank_sampler into one bundle.
//   Requester side : req (in to controller), ack, rdata, busy (out)
//   Bank side      : bank_freeze, bank_addr (out), bank_data (in)
//   modport slave  : the controller's view
//   modport master : the view of the environment (requesters + bank)
interface rnd_bank_sampler_if #(
    parameter int ADDR_W = 6
) ();
    logic [1:0]        req;
    logic [1:0]        ack;
    logic [15:0]       rdata;
    logic              busy;
    logic              bank_freeze;
    logic [ADDR_W-1:0] bank_addr;
    logic [15:0]       bank_data;

    modport slave (
        input  req,
        input  bank_data,
        output ack,
        output rdata,
        output busy,
        output bank_freeze,
        output bank_addr
    );

    modport master (
        output req,
        output bank_data,
        input  ack,
        input  rdata,
        input  busy,
        input  bank_freeze,
        input  bank_addr
    );
endinterface

// File: rtl/rnd_bank_sampler.sv
// rnd_bank_sampler
//   Shares a bank of free-running random generators between two requesters.
//   A granted request freezes the bank, lets the gated outputs settle,
//   samples one entry, releases the bank, and repeats for MIX entries; the
//   XOR of the samples is returned with a one-cycle ack.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - rnd_bank_sampler_if.slave (req/ack/rdata/busy, bank_freeze/
//            bank_addr/bank_data)
module rnd_bank_sampler #(
    parameter int RND_N  = 36,
    parameter int ADDR_W = $clog2(RND_N),
    parameter int SETTLE = 2,
    parameter int RUN    = 4,
    parameter int MIX    = 2
) (
    input  logic               clk,
    input  logic               rst,
    rnd_bank_sampler_if.slave  bus
);
    localparam int TMAX = (SETTLE > RUN) ? SETTLE : RUN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(MIX + 1);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RND_N - 1);
    localparam logic [TW-1:0]     SETTLE_LD = TW'(SETTLE - 1);
    localparam logic [TW-1:0]     RUN_LD    = TW'(RUN - 1);
    localparam logic [CW-1:0]     MIX_C     = CW'(MIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_SAMPLE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0]       acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [15:0]       rdata_q, rdata_d;

    logic [15:0]       acc_new;
    logic [CW-1:0]     cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;   // requester 0 wins the first tie
            ack_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ack_d      = 2'b00;
        rdata_d    = rdata_q;
        acc_new    = acc_q ^ bus.bank_data;
        cnt_inc    = cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    // On a tie, the requester that did not win last time goes.
                    gnt_d   = (bus.req == 2'b11) ? ~last_gnt_q : bus.req[1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    timer_d = SETTLE_LD;
                    state_d = S_FREEZE;
                end
            end
            S_FREEZE: begin
                if (timer_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SAMPLE: begin
                acc_d  = acc_new;
                cnt_d  = cnt_inc;
                // Explicit compare so a non-power-of-2 bank wraps correctly.
                addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                if (cnt_inc == MIX_C) begin
                    // Register ack/rdata here so both appear in the DONE cycle.
                    ack_d[gnt_q] = 1'b1;
                    rdata_d      = acc_new;
                    state_d      = S_DONE;
                end else begin
                    timer_d = RUN_LD;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (timer_q == '0) begin
                    timer_d = SETTLE_LD;
                    state_d = S_FREEZE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DONE: begin
                last_gnt_d = gnt_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.bank_freeze = (state_q == S_FREEZE) || (state_q == S_SAMPLE);
    assign bus.bank_addr   = addr_q;
endmodule

// File: tb/tb_rnd_bank_sampler.sv
// tb_rnd_bank_sampler
//   Directed bench for rnd_bank_sampler. Two instances: one with default
//   parameters, one with MIX=1 for the address-wrap sequence. The bank is
//   modelled as bank_data = 16'h0100 + bank_addr.
module tb_rnd_bank_sampler;
    logic clk;
    logic rst;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    rnd_bank_sampler_if #(.ADDR_W(6)) bus  ();
    rnd_bank_sampler_if #(.ADDR_W(6)) bus2 ();

    assign bus.bank_data  = 16'h0100 + {10'b0, bus.bank_addr};
    assign bus2.bank_data = 16'h0100 + {10'b0, bus2.bank_addr};

    rnd_bank_sampler #(
        .RND_N(36), .ADDR_W(6), .SETTLE(2), .RUN(4), .MIX(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rnd_bank_sampler #(
        .RND_N(36), .ADDR_W(6), .SETTLE(2), .RUN(4), .MIX(1)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic bad;
        logic exp_frz;
        int   n;

        rst = 1'b1;
        bus.req  = 2'b00;
        bus2.req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ack",    32'(bus.ack),         32'h0);
        chk("rst_rdata",  32'(bus.rdata),       32'h0);
        chk("rst_busy",   32'(bus.busy),        32'h0);
        chk("rst_freeze", 32'(bus.bank_freeze), 32'h0);
        chk("rst_addr",   32'(bus.bank_addr),   32'h0);

        // Single request from requester 0, held
        rst = 1'b0;
        bus.req = 2'b01;
        bad = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exp_frz = (c <= 3) || (c >= 8 && c <= 10);
            if (bus.bank_freeze !== exp_frz) bad = 1'b1;
            if (c < 11 && bus.ack !== 2'b00) bad = 1'b1;
            if (c == 1) chk("single_busy_c1", 32'(bus.busy), 32'h1);
        end
        chk("single_freeze_pattern", 32'(bad),       32'h0);
        chk("single_ack",            32'(bus.ack),   32'h1);
        chk("single_rdata",          32'(bus.rdata), 32'h0001);
        chk("single_addr",           32'(bus.bank_addr), 32'h2);
        chk("single_busy_done",      32'(bus.busy),  32'h1);
        bus.req = 2'b00;

        // Drop request mid-transaction
        @(negedge clk);
        chk("drop_idle_busy", 32'(bus.busy), 32'h0);
        bus.req = 2'b01;
        repeat (3) @(negedge clk);
        bus.req = 2'b00;
        repeat (8) @(negedge clk);
        chk("drop_ack",   32'(bus.ack),       32'h1);
        chk("drop_rdata", 32'(bus.rdata),     32'h0001);
        chk("drop_addr",  32'(bus.bank_addr), 32'h4);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.ack !== 2'b00) bad = 1'b1;
        end
        chk("drop_no_regrant", 32'(bad), 32'h0);

        // Reset mid-operation (cycle 5 of a request from requester 1)
        bus.req = 2'b10;
        repeat (5) @(negedge clk);
        chk("midrst_pre_busy", 32'(bus.busy),      32'h1);
        chk("midrst_pre_addr", 32'(bus.bank_addr), 32'h5);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy",   32'(bus.busy),        32'h0);
        chk("midrst_freeze", 32'(bus.bank_freeze), 32'h0);
        chk("midrst_ack",    32'(bus.ack),         32'h0);
        chk("midrst_rdata",  32'(bus.rdata),       32'h0);
        chk("midrst_addr",   32'(bus.bank_addr),   32'h0);
        bus.req = 2'b00;
        @(negedge clk);
        chk("midrst_hold_ack", 32'(bus.ack), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Tie arbitration, both held; first tie after reset goes to 0
        bus.req = 2'b11;
        bad = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 11) begin
                chk("tie_ack_11",   32'(bus.ack),       32'h1);
                chk("tie_rdata_11", 32'(bus.rdata),     32'h0001);
                chk("tie_addr_11",  32'(bus.bank_addr), 32'h2);
            end else if (c == 23) begin
                chk("tie_ack_23",   32'(bus.ack),       32'h2);
                chk("tie_rdata_23", 32'(bus.rdata),     32'h0001);
                chk("tie_addr_23",  32'(bus.bank_addr), 32'h4);
            end else if (c == 35) begin
                chk("tie_ack_35",   32'(bus.ack),       32'h1);
                chk("tie_addr_35",  32'(bus.bank_addr), 32'h6);
            end else if (bus.ack !== 2'b00) begin
                bad = 1'b1;
            end
        end
        chk("tie_no_stray_ack", 32'(bad), 32'h0);
        bus.req = 2'b00;

        // Address wrap on the MIX=1 instance, requester 1 held for 37 requests
        @(negedge clk);
        bus2.req = 2'b10;
        bad = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (bus2.bank_addr > 6'd35) bad = 1'b1;
            end while (bus2.ack == 2'b00 && n < 20);
            chk($sformatf("wrap_lat_%0d", k), 32'(n), (k == 1) ? 32'd4 : 32'd5);
            chk($sformatf("wrap_ack_%0d", k), 32'(bus2.ack), 32'h2);
            chk($sformatf("wrap_rdata_%0d", k), 32'(bus2.rdata), 32'(16'h0100 + 16'((k - 1) % 36)));
            chk($sformatf("wrap_addr_%0d", k), 32'(bus2.bank_addr), 32'(k % 36));
        end
        chk("wrap_addr_bound", 32'(bad), 32'h0);
        bus2.req = 2'b00;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
